shared_bus_arbiter: RTL
=======================

# shared_bus_arbiter

Round-robin arbiter and bus sampler for the shared tri-state data bus. Each of N requesters owns a tri-state driver (data input, enable input, output high-Z when disabled); this block generates those driver enables as a one-hot grant vector, inserts a one-cycle turnaround between owners so two drivers never overlap, caps bus tenure, and registers the resolved bus value each owned cycle for the downstream consumer.

## Interface
- N, 4, number of requesters / tri-state drivers (2..8)
- W, 4, bus data width
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure (>=1)
- clk  input  1  rising-edge clock, the block's only clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  request per requester; held high while the bus is wanted
- bus  input  W  resolved shared bus (wired-OR of all tri-state driver outputs)
- grant  output  N  one-hot driver enables; all-zero means bus floats (Z)
- busy  output  1  high while any grant bit is high
- owner  output  log2(N) (min 1)  index of current grant holder; 0 when idle
- rx_valid  output  1  one-cycle strobe: rx_data/rx_src updated
- rx_data  output  W  bus value sampled during the previous owned cycle
- rx_src  output  log2(N) (min 1)  requester index that drove rx_data

## Operation
- Single clock, clk; asynchronous active-high reset, rst. All outputs registered.
- Reset values: grant=0, busy=0, owner=0, rx_valid=0, rx_data=0, rx_src=0, state=IDLE, hold counter=0, priority pointer last=N-1 (index 0 wins first).
- States: IDLE, GRANT, TURN.
- IDLE: if req!=0, pick winner = first set bit scanning last+1, last+2, ... mod N; next cycle grant=onehot(winner), owner=winner, last=winner, counter=1, -> GRANT. Else stay.
- GRANT: each cycle, at the edge: if req[owner]==0 or counter==MAX_HOLD -> grant=0, busy=0, -> TURN; else counter+1, stay. Other requesters never preempt.
- TURN: exactly one cycle with grant=0 (bus high-Z, contention guard). At its end, same arbitration as IDLE: winner -> GRANT directly; none -> IDLE.
- Preempted owner still requesting is eligible again but ranks last (pointer already advanced).
- Sampling: at every edge where grant!=0 was held the preceding cycle, rx_data<=bus, rx_src<=owner, rx_valid<=1; otherwise rx_valid<=0 (rx_data/rx_src hold).
- Counter width ceil(log2(MAX_HOLD+1)); never wraps (reset to 1 on each new grant).
- Invariant: grant is zero or one-hot in every cycle, including after reset.

## Timing
- Arbitration latency: req rising before edge k (from IDLE) -> grant high from edge k for cycle k..; one cycle.
- Release latency: req[owner] low sampled at edge k -> grant low after edge k.
- Back-to-back owners: exactly one all-zero grant cycle between tenures; no two consecutive cycles with different nonzero grants.
- Max tenure: MAX_HOLD cycles of grant high.
- rx_valid lags grant by one cycle; a tenure of L cycles yields exactly L rx_valid strobes, the last one in the TURN cycle.
- rst asserted mid-tenure: grant/busy drop immediately (asynchronous), bus floats; pointer returns to N-1; in-flight sample discarded (rx_valid=0).
- req of an unselected requester toggling during a tenure has no effect.

## Test plan
- Reset: rst=1 mid-tenure with grant=0010 -> grant=0000, rx_valid=0 same cycle without a clock edge; after release, req=1111 -> grant=0001 one cycle later.
- Single requester: req=0100 held 3 cycles then dropped, bus=4'hA -> grant=0100 for 3 cycles, then 0000; 3 rx_valid strobes, rx_data=4'hA, rx_src=2.
- Round robin: req=1111 held, MAX_HOLD=2 -> grant sequence 0001,0001,0000,0010,0010,0000,0100,... , never two nonzero grants adjacent.
- Preemption: req=0001 held 20 cycles, MAX_HOLD=8 -> grant 0001 for 8 cycles, one 0000 cycle, 0001 again for 8.
- Sampling: owner 3 drives bus 4'h5,4'h6,4'h7 over its tenure -> rx_data 5,6,7 on consecutive rx_valid cycles, rx_src=3, rx_valid low otherwise.
- Contention check: random req for 10k cycles -> grant always zero or one-hot, turnaround always present, every requester granted within N*(MAX_HOLD+1) cycles of request.

Source files
------------

// File: rtl/shared_bus_arbiter_if.sv
// Handshake and bus signals between the shared-bus arbiter and its requesters/consumer.
// The arbiter uses the master modport; the environment uses the slave modport.
interface shared_bus_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int OW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [W-1:0]  bus;
  logic [N-1:0]  grant;
  logic          busy;
  logic [OW-1:0] owner;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic [OW-1:0] rx_src;

  modport master (
    input  req, bus,
    output grant, busy, owner, rx_valid, rx_data, rx_src
  );

  modport slave (
    output req, bus,
    input  grant, busy, owner, rx_valid, rx_data, rx_src
  );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin tri-state bus arbiter: one-hot driver enables, one-cycle turnaround
// between owners, capped tenure, and a registered sample of the bus per owned cycle.
module shared_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shared_bus_arbiter_if.master   bif
);
  localparam int OW = (N > 2) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rxv_q;
  logic [W-1:0]  rxd_q;
  logic [OW-1:0] rxs_q;

  logic          win_found;
  logic [OW-1:0] win_idx;

  // Scan last+1, last+2, ... so the most recent owner ranks last.
  always_comb begin : arb
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && bif.req[idx[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, TURN: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = N'(1) << win_idx;
          busy_d  = 1'b1;
          owner_d = win_idx;
          last_d  = win_idx;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          owner_d = '0;
        end
      end
      GRANT: begin
        // No preemption: only the owner's own request or the tenure cap ends it.
        if (!bif.req[owner_q] || cnt_q == CW'(MAX_HOLD)) begin
          state_d = TURN;
          grant_d = '0;
          busy_d  = 1'b0;
          owner_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sample the resolved bus at the end of every owned cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxv_q <= 1'b0;
      rxd_q <= '0;
      rxs_q <= '0;
    end else if (|grant_q) begin
      rxv_q <= 1'b1;
      rxd_q <= bif.bus;
      rxs_q <= owner_q;
    end else begin
      rxv_q <= 1'b0;
    end
  end

  assign bif.grant    = grant_q;
  assign bif.busy     = busy_q;
  assign bif.owner    = owner_q;
  assign bif.rx_valid = rxv_q;
  assign bif.rx_data  = rxd_q;
  assign bif.rx_src   = rxs_q;
endmodule
